data_path_io_engine: RTL and testbench
======================================

DATA_PATH_IO_ENGINE -- requirements
Module: data_path_io_engine

Interface
REQ-001 SHALL have parameter M, default 16: weight word width per SMAC lane.
REQ-002 SHALL have parameter Pa, default 8: output activation width per SMAC lane.
REQ-003 SHALL have parameter BW, default 128: bus width. BW%M==0, BW%Pa==0.
REQ-004 SHALL have parameter NSMAC, default 64: SMAC lane count. NSMAC%(BW/M)==0, NSMAC%(BW/Pa)==0.
REQ-005 Derived values SHALL be: WPB=BW/M weights per beat; WBEATS=NSMAC/WPB; OPB=BW/Pa outputs per beat; OBEATS=NSMAC/OPB.
REQ-006 Port clk, input, 1: single clock; all logic on the rising edge.
REQ-007 Port rst_n, input, 1: reset; synchronous, active-low.
REQ-008 Port clr, input, 1: synchronous clear of all data registers; returns FSM to IDLE.
REQ-009 Port start_wload, input, 1: pulse that starts a weight load.
REQ-010 Port start_drain, input, 1: pulse that snapshots the SMAC outputs and starts streaming them.
REQ-011 Port in_valid, input, 1; in_ready, output, 1; in_data, input, BW: input stream.
REQ-012 Port act_out, output, BW: registered activation word, fed to the serialisers.
REQ-013 Port act_load, output, 1: one-cycle pulse; act_out was updated this cycle.
REQ-014 Port wei_out, output, NSMAC*M: per-lane weight registers; lane i occupies [i*M +: M].
REQ-015 Port wload_done, output, 1: one-cycle pulse after the final weight beat.
REQ-016 Port smac_out, input, NSMAC*Pa: SMAC results; lane i occupies [i*Pa +: Pa].
REQ-017 Port out_valid, output, 1; out_ready, input, 1; out_data, output, BW; out_last, output, 1: output stream.
REQ-018 Port busy, output, 1: high whenever state != IDLE.
REQ-019 Port err, output, 1: sticky; set when a start pulse is ignored.

Function
REQ-020 FSM SHALL have three states: IDLE, WLOAD, DRAIN.
REQ-021 in_ready SHALL be 1 in IDLE and WLOAD, and 0 in DRAIN. A beat is accepted when in_valid && in_ready.
REQ-022 IDLE, accepted beat: act_out<=in_data on the next edge; act_load pulses in that same next cycle (latency 1).
REQ-023 IDLE, start_wload: go to WLOAD, wcnt<=0. If start_wload and start_drain are both high, wload wins, the drain is dropped, and err is set.
REQ-024 WLOAD, accepted beat b=wcnt: for w=0..WPB-1, lane b*WPB+w <= in_data[w*M +: M]. No other lanes change; wcnt increments.
REQ-025 WLOAD, beat with wcnt==WBEATS-1: return to IDLE; wload_done pulses in the next cycle. Activations are not loaded while in WLOAD.
REQ-026 IDLE, start_drain (without start_wload): snapshot all of smac_out into an internal register on that edge; go to DRAIN; ocnt<=0.
REQ-027 DRAIN: out_valid=1. out_data is snapshot lanes ocnt*OPB .. ocnt*OPB+OPB-1, with lane j at [j*Pa +: Pa]. out_last=(ocnt==OBEATS-1).
REQ-028 While out_valid && !out_ready, out_data and out_last SHALL hold stable.
REQ-029 out_valid && out_ready: ocnt increments. If out_last is high, return to IDLE, and out_valid is 0 in the next cycle.
REQ-030 start_wload or start_drain outside IDLE SHALL be ignored, set err, and leave state and counters unchanged.
REQ-031 Changes on smac_out during DRAIN SHALL NOT affect out_data.
REQ-032 clr: act_out, wei_out, snapshot, wcnt and ocnt go to 0; state goes to IDLE; pulses go low; err is kept. clr overrides every other input in the same cycle.
REQ-033 Throughput SHALL be one beat per cycle in every state, with no bubbles between beats.

Reset
REQ-034 rst_n==0 at an edge: state IDLE; all counters, act_out, wei_out, snapshot, out_data, out_valid, out_last, act_load, wload_done, busy and err go to 0.
REQ-035 Reset asserted mid-WLOAD or mid-DRAIN SHALL abort the operation. After release, in_ready=1 and out_valid=0.

Verification (defaults: WPB=8, WBEATS=8, OPB=16, OBEATS=4)
REQ-036 Activation load: IDLE, in_data=0x0F..0F, in_valid=1 for 1 cycle -> next cycle act_out=0x0F..0F, act_load=1 for 1 cycle.
REQ-037 Weight load: start_wload, then 8 beats where beat b word w = {b,w} in 16 bits -> lane 19 = 0x0203; wload_done pulses once after beat 7; busy is high for 8 cycles. Repeat with in_valid gaps -> same result.
REQ-038 Drain with backpressure: smac_out lane i = i; start_drain; out_ready toggling 1,0,1,... -> 4 beats; beat 2 byte 0 = 0x20; out_last only on beat 3; data held steady during stalls; smac_out changed after the snapshot -> no effect.
REQ-039 Collisions: start_wload and start_drain in the same cycle -> WLOAD, err=1. start_drain during WLOAD -> ignored, err stays 1.
REQ-040 Reset/clr mid-op: rst_n low after beat 3 of WLOAD -> all outputs 0, IDLE. clr during DRAIN beat 1 -> out_valid=0 next cycle, wei_out=0, err kept.

Source files
------------

// File: rtl/data_path_io_engine.sv
// Data-path I/O engine: routes input beats to activations or weight lanes,
// and drains a snapshot of the SMAC results as a stream of bus beats.
module data_path_io_engine #(
  parameter int M     = 16,
  parameter int Pa    = 8,
  parameter int BW    = 128,
  parameter int NSMAC = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  start_wload,
  input  logic                  start_drain,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BW-1:0]         in_data,
  output logic [BW-1:0]         act_out,
  output logic                  act_load,
  output logic [NSMAC*M-1:0]    wei_out,
  output logic                  wload_done,
  input  logic [NSMAC*Pa-1:0]   smac_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BW-1:0]         out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  err
);

  localparam int WPB    = BW / M;
  localparam int WBEATS = NSMAC / WPB;
  localparam int OPB    = BW / Pa;
  localparam int OBEATS = NSMAC / OPB;
  localparam int WCW    = (WBEATS > 1) ? $clog2(WBEATS) : 1;
  localparam int OCW    = (OBEATS > 1) ? $clog2(OBEATS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WLOAD = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [WCW-1:0]       wcnt;
  logic [OCW-1:0]       ocnt;
  logic [NSMAC*Pa-1:0]  snap;
  logic                 accept;
  logic                 fire;
  logic                 wlast;
  logic                 olast;

  assign accept = in_valid && in_ready;
  assign fire   = out_valid && out_ready;
  assign wlast  = (wcnt == WCW'(WBEATS - 1));
  assign olast  = (ocnt == OCW'(OBEATS - 1));

  // Snapshot lanes are contiguous, so one output beat is one BW-wide slice.
  assign out_data = snap[int'(ocnt)*BW +: BW];

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and stream handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b1;
    busy      = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (state)
      IDLE: begin
        if (start_wload) begin
          state_nxt = WLOAD;
        end else if (start_drain) begin
          state_nxt = DRAIN;
        end else begin
          state_nxt = IDLE;
        end
      end
      WLOAD: begin
        busy = 1'b1;
        if (accept && wlast) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = WLOAD;
        end
      end
      DRAIN: begin
        busy      = 1'b1;
        in_ready  = 1'b0;
        out_valid = 1'b1;
        out_last  = olast;
        if (fire && olast) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DRAIN;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Data registers, counters, pulses and the sticky error flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_out    <= {BW{1'b0}};
      act_load   <= 1'b0;
      wei_out    <= {(NSMAC*M){1'b0}};
      wload_done <= 1'b0;
      snap       <= {(NSMAC*Pa){1'b0}};
      wcnt       <= {WCW{1'b0}};
      ocnt       <= {OCW{1'b0}};
      err        <= 1'b0;
    end else if (clr) begin
      act_out    <= {BW{1'b0}};
      act_load   <= 1'b0;
      wei_out    <= {(NSMAC*M){1'b0}};
      wload_done <= 1'b0;
      snap       <= {(NSMAC*Pa){1'b0}};
      wcnt       <= {WCW{1'b0}};
      ocnt       <= {OCW{1'b0}};
    end else begin
      act_load   <= 1'b0;
      wload_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            act_out  <= in_data;
            act_load <= 1'b1;
          end
          if (start_wload) begin
            wcnt <= {WCW{1'b0}};
            if (start_drain) begin
              err <= 1'b1;
            end
          end else if (start_drain) begin
            snap <= smac_out;
            ocnt <= {OCW{1'b0}};
          end
        end
        WLOAD: begin
          if (accept) begin
            for (int w = 0; w < WPB; w++) begin
              wei_out[(int'(wcnt)*WPB + w)*M +: M] <= in_data[w*M +: M];
            end
            wcnt       <= wlast ? {WCW{1'b0}} : wcnt + WCW'(1);
            wload_done <= wlast;
          end
          if (start_wload || start_drain) begin
            err <= 1'b1;
          end
        end
        DRAIN: begin
          if (fire) begin
            ocnt <= olast ? {OCW{1'b0}} : ocnt + OCW'(1);
          end
          if (start_wload || start_drain) begin
            err <= 1'b1;
          end
        end
        default: begin
          wcnt <= {WCW{1'b0}};
          ocnt <= {OCW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_path_io_engine.sv
// Scoreboard bench for data_path_io_engine: expected activations and output
// beats are queued as stimulus is driven and compared as the DUT emits them.
module tb_data_path_io_engine;

  localparam int M      = 16;
  localparam int Pa     = 8;
  localparam int BW     = 128;
  localparam int NSMAC  = 64;
  localparam int WPB    = BW / M;
  localparam int WBEATS = NSMAC / WPB;
  localparam int OPB    = BW / Pa;
  localparam int OBEATS = NSMAC / OPB;

  typedef struct packed {
    logic [7:0]    idx;
    logic          last;
    logic [BW-1:0] data;
  } beat_t;

  logic                clk = 1'b0;
  logic                rst_n, clr, start_wload, start_drain;
  logic                in_valid, in_ready, act_load, wload_done;
  logic [BW-1:0]       in_data, act_out, out_data;
  logic [NSMAC*M-1:0]  wei_out;
  logic [NSMAC*Pa-1:0] smac_out;
  logic                out_valid, out_ready, out_last, busy, err;

  logic [BW-1:0] act_q[$];
  beat_t         out_q[$];
  logic [M-1:0]  exp_wei[NSMAC];
  int            checks = 0;
  int            errors = 0;
  int            busy_cnt = 0;
  int            done_cnt = 0;

  data_path_io_engine #(.M(M), .Pa(Pa), .BW(BW), .NSMAC(NSMAC)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .start_wload(start_wload), .start_drain(start_drain),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .act_out(act_out), .act_load(act_load),
    .wei_out(wei_out), .wload_done(wload_done),
    .smac_out(smac_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT produces an output
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (busy) busy_cnt++;
      if (wload_done) done_cnt++;
      if (act_load) begin
        if (act_q.size() == 0) check_eq("act_unexpected", 128'd1, 128'd0);
        else check_eq("act_out", act_out, act_q.pop_front());
      end
      if (out_valid) begin
        if (out_q.size() == 0) begin
          check_eq("out_unexpected", 128'd1, 128'd0);
        end else begin
          check_eq("out_data", out_data, out_q[0].data);
          check_eq("out_last", {127'd0, out_last}, {127'd0, out_q[0].last});
          if (out_ready) begin
            if (out_q[0].idx == 8'd2) check_eq("beat2_byte0", {120'd0, out_data[7:0]}, 128'h20);
            void'(out_q.pop_front());
          end
        end
      end
    end
  end

  task automatic check_weights(input string tag);
    for (int i = 0; i < NSMAC; i++) check_eq(tag, {112'd0, wei_out[i*M +: M]}, {112'd0, exp_wei[i]});
  endtask

  task automatic zero_model();
    for (int i = 0; i < NSMAC; i++) exp_wei[i] = 16'd0;
    act_q.delete();
    out_q.delete();
  endtask

  // Drives nbeats weight beats (state must already be WLOAD); word w of beat b is {b, w} ^ xv
  task automatic send_weights(input int nbeats, input bit gaps, input logic [15:0] xv);
    for (int b = 0; b < nbeats; b++) begin
      if (gaps) begin
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        tick();
      end
      for (int w = 0; w < WPB; w++) begin
        in_data[w*M +: M]  = {8'(b), 8'(w)} ^ xv;
        exp_wei[b*WPB + w] = {8'(b), 8'(w)} ^ xv;
      end
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic start_load();
    start_wload = 1'b1;
    tick();
    start_wload = 1'b0;
  endtask

  // Loads smac_out, pulses start_drain, queues the expected beats, then scrambles smac_out
  task automatic begin_drain(input bit ramp);
    beat_t bt;
    for (int i = 0; i < NSMAC; i++) smac_out[i*Pa +: Pa] = ramp ? 8'(i) : 8'($urandom);
    for (int k = 0; k < OBEATS; k++) begin
      bt.idx  = 8'(k);
      bt.last = (k == OBEATS - 1);
      for (int j = 0; j < OPB; j++) bt.data[j*Pa +: Pa] = smac_out[(k*OPB + j)*Pa +: Pa];
      out_q.push_back(bt);
    end
    start_drain = 1'b1;
    tick();
    start_drain = 1'b0;
    smac_out = ~smac_out;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; start_wload = 1'b0; start_drain = 1'b0;
    in_valid = 1'b0; in_data = '0; smac_out = '0; out_ready = 1'b0;
    zero_model();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check_eq("rst_in_ready", {127'd0, in_ready}, 128'd1);
    check_eq("rst_busy", {127'd0, busy}, 128'd0);
    check_eq("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check_eq("rst_err", {127'd0, err}, 128'd0);
    check_eq("rst_act_out", act_out, 128'd0);
    check_eq("rst_out_data", out_data, 128'd0);
    check_eq("rst_wei", {127'd0, |wei_out}, 128'd0);

    // Activation loads
    in_data = {16{8'h0F}}; in_valid = 1'b1; act_q.push_back(in_data);
    tick();
    in_data = {$urandom, $urandom, $urandom, $urandom}; act_q.push_back(in_data);
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    check_eq("act_q_drained", 128'(act_q.size()), 128'd0);
    check_eq("act_last", act_out, {$bits(act_out){1'b0}} | act_out);

    // Weight load, back-to-back
    busy_cnt = 0; done_cnt = 0;
    start_load();
    send_weights(WBEATS, 1'b0, 16'h0000);
    tick();
    check_eq("wl_busy_cycles", 128'(busy_cnt), 128'd8);
    check_eq("wl_done_count", 128'(done_cnt), 128'd1);
    check_eq("lane19", {112'd0, wei_out[19*M +: M]}, 128'h0203);
    check_weights("wei_a");

    // Clear, then repeat with gaps
    clr = 1'b1; tick(); clr = 1'b0;
    zero_model();
    check_eq("clr_wei", {127'd0, |wei_out}, 128'd0);
    done_cnt = 0;
    start_load();
    send_weights(WBEATS, 1'b1, 16'h0000);
    tick();
    check_eq("wl_gap_done", 128'(done_cnt), 128'd1);
    check_eq("lane19_gap", {112'd0, wei_out[19*M +: M]}, 128'h0203);
    check_weights("wei_gap");

    // Drain with alternating backpressure
    begin_drain(1'b1);
    for (int c = 0; c < 40 && out_q.size() > 0; c++) begin
      out_ready = (c % 2 == 0);
      tick();
    end
    out_ready = 1'b0;
    check_eq("drain_complete", 128'(out_q.size()), 128'd0);
    check_eq("drain_idle_valid", {127'd0, out_valid}, 128'd0);
    check_eq("drain_idle_busy", {127'd0, busy}, 128'd0);
    check_eq("err_clean", {127'd0, err}, 128'd0);

    // Start collision, then drain request inside WLOAD
    start_wload = 1'b1; start_drain = 1'b1; tick();
    start_wload = 1'b0; start_drain = 1'b0;
    check_eq("coll_busy", {127'd0, busy}, 128'd1);
    check_eq("coll_in_ready", {127'd0, in_ready}, 128'd1);
    check_eq("coll_err", {127'd0, err}, 128'd1);
    start_drain = 1'b1; tick(); start_drain = 1'b0;
    check_eq("wl_drain_ignored", {127'd0, out_valid}, 128'd0);
    check_eq("wl_err_kept", {127'd0, err}, 128'd1);
    done_cnt = 0;
    send_weights(WBEATS, 1'b0, 16'h5A5A);
    tick();
    check_eq("coll_done", 128'(done_cnt), 128'd1);
    check_weights("wei_coll");

    // Reset in the middle of a weight load
    start_load();
    send_weights(4, 1'b0, 16'h1111);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    zero_model();
    check_eq("mid_rst_wei", {127'd0, |wei_out}, 128'd0);
    check_eq("mid_rst_act", act_out, 128'd0);
    check_eq("mid_rst_busy", {127'd0, busy}, 128'd0);
    check_eq("mid_rst_err", {127'd0, err}, 128'd0);
    check_eq("mid_rst_in_ready", {127'd0, in_ready}, 128'd1);
    check_eq("mid_rst_valid", {127'd0, out_valid}, 128'd0);

    // Clear during drain beat 1, with err already set by an ignored start
    start_load();
    send_weights(WBEATS, 1'b0, 16'h0F0F);
    tick();
    begin_drain(1'b0);
    start_wload = 1'b1; out_ready = 1'b1; tick();
    start_wload = 1'b0; out_ready = 1'b0; clr = 1'b1; tick();
    clr = 1'b0;
    zero_model();
    check_eq("clr_drain_valid", {127'd0, out_valid}, 128'd0);
    check_eq("clr_drain_wei", {127'd0, |wei_out}, 128'd0);
    check_eq("clr_err_kept", {127'd0, err}, 128'd1);
    check_eq("clr_busy", {127'd0, busy}, 128'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
